// File: rtl/framebuffer_port_arbiter_if.sv
// Requester, framebuffer-RAM and status signals of the framebuffer port arbiter.
// slave = arbiter side, master = requesters plus RAM (the environment).
interface framebuffer_port_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [9:0]  x0, x1;
  logic [9:0]  y0, y1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  req0, req1, we0, we1, x0, x1, y0, y1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata, mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport master (
    output req0, req1, we0, we1, x0, x1, y0, y1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata, mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/framebuffer_port_arbiter.sv
// Two-port arbiter sequencing pixel-addressed accesses onto the single framebuffer RAM port.
// Define FB_ARB_DISPLAY_PRIORITY_EN to give port 0 strict priority on simultaneous requests.

module fbpa_coord_decode #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PIX_PER_WORD = 8
) (
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  output logic [15:0] addr_o,
  output logic        oor_o
);
  localparam int SHIFT = $clog2(PIX_PER_WORD);

  logic [18:0] lin;

  // Word holding the pixel; unaligned x simply drops the in-word pixel index.
  assign lin    = 19'(y_i) * 19'(WIDTH) + 19'(x_i);
  assign addr_o = 16'(lin >> SHIFT);
  assign oor_o  = (int'(x_i) >= WIDTH) || (int'(y_i) >= HEIGHT);
endmodule

module framebuffer_port_arbiter #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PIX_PER_WORD = 8,
  parameter int WRITE_HOLD   = 3,
  parameter int READ_LATENCY = 2
) (
  input logic                         clk,
  input logic                         reset,
  framebuffer_port_arbiter_if.slave   bus
);
  localparam int NUM_PORTS = 2;
  localparam int CNT_MAX   = (WRITE_HOLD > READ_LATENCY) ? WRITE_HOLD : READ_LATENCY;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RWAIT, S_ACK} state_t;

  logic [NUM_PORTS-1:0]        req_v, we_v, oor_v;
  logic [NUM_PORTS-1:0][9:0]   x_v, y_v;
  logic [NUM_PORTS-1:0][31:0]  wdata_v;
  logic [NUM_PORTS-1:0][15:0]  addr_v;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              err_q, err_d;
  logic              skip_q, skip_d;
  logic [15:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick;
  logic              in_ack;

  assign req_v   = {bus.req1, bus.req0};
  assign we_v    = {bus.we1, bus.we0};
  assign x_v     = {bus.x1, bus.x0};
  assign y_v     = {bus.y1, bus.y0};
  assign wdata_v = {bus.wdata1, bus.wdata0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    fbpa_coord_decode #(
      .WIDTH        (WIDTH),
      .HEIGHT       (HEIGHT),
      .PIX_PER_WORD (PIX_PER_WORD)
    ) u_dec (
      .x_i    (x_v[p]),
      .y_i    (y_v[p]),
      .addr_o (addr_v[p]),
      .oor_o  (oor_v[p])
    );
  end

  always_comb begin
    pick = req_v[1] & ~req_v[0];
    if (req_v[0] && req_v[1]) begin
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
      pick = 1'b0;
`else
      pick = ~last_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    skip_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The cycle right after ACK is ignored so a requester has time to drop req.
        if (!skip_q && (req_v != '0)) begin
          port_d  = pick;
          last_d  = pick;
          err_d   = oor_v[pick];
          addr_d  = addr_v[pick];
          wdata_d = wdata_v[pick];
          rdata_d = '0;
          cnt_d   = '0;
          if (oor_v[pick])     state_d = S_ACK;
          else if (we_v[pick]) state_d = S_WRITE;
          else                 state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(WRITE_HOLD - 1)) state_d = S_ACK;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      S_READ: begin
        cnt_d = '0;
        if (READ_LATENCY == 1) begin
          rdata_d = bus.mem_rdata;
          state_d = S_ACK;
        end else begin
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 2)) begin
          rdata_d = bus.mem_rdata;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        skip_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ack        = (state_q == S_ACK);
  assign bus.ack0      = in_ack & ~port_q;
  assign bus.ack1      = in_ack &  port_q;
  assign bus.err0      = in_ack & ~port_q & err_q;
  assign bus.err1      = in_ack &  port_q & err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_re    = (state_q == S_READ);
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Bench for framebuffer_port_arbiter: vector table, multi-cycle corner sequences and
// randomized transactions checked against a pixel-level reference model.
module tb_framebuffer_port_arbiter;
  localparam int W   = 640;
  localparam int H   = 480;
  localparam int PPW = 8;
  localparam int WH  = 3;
  localparam int RL  = 2;

`ifdef FB_ARB_DISPLAY_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    bit          port;
    bit          we;
    int          x;
    int          y;
    logic [31:0] wd;
    logic [15:0] addr;
    bit          err;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  framebuffer_port_arbiter_if bus();

  framebuffer_port_arbiter #(
    .WIDTH(W), .HEIGHT(H), .PIX_PER_WORD(PPW), .WRITE_HOLD(WH), .READ_LATENCY(RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] ref_mem [0:65535];

  function automatic logic [31:0] pat(input int i);
    return (i == 0) ? 32'h12345678 : 32'(i) * 32'h9E3779B1;
  endfunction

  // RAM model: data of a read appears in the cycle after mem_re, junk otherwise.
  initial begin
    logic [31:0] fbmem [0:65535];
    for (int i = 0; i < 65536; i++) fbmem[i] = pat(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_we) fbmem[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= fbmem[bus.mem_addr];
      else            bus.mem_rdata <= $urandom;
    end
  end

  int          we_tot = 0, re_tot = 0, ovl_tot = 0, uns_tot = 0, ack_tot = 0;
  logic [15:0] s_addr = '0, prev_addr = '0;
  logic [31:0] s_wdata = '0, prev_wd = '0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we) we_tot++;
    if (bus.mem_re) re_tot++;
    if (bus.mem_we && bus.mem_re) ovl_tot++;
    if (bus.ack0 && bus.ack1) ovl_tot++;
    if (bus.mem_we && prev_we && (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wd)) uns_tot++;
    if (bus.mem_we || bus.mem_re) begin
      s_addr  = bus.mem_addr;
      s_wdata = bus.mem_wdata;
    end
    if (bus.ack0 || bus.ack1) ack_tot++;
    prev_we   = bus.mem_we;
    prev_addr = bus.mem_addr;
    prev_wd   = bus.mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit rq, input bit w, input int x, input int y,
                       input logic [31:0] wd);
    if (p) begin
      bus.req1 = rq; bus.we1 = w; bus.x1 = 10'(x); bus.y1 = 10'(y); bus.wdata1 = wd;
    end else begin
      bus.req0 = rq; bus.we0 = w; bus.x0 = 10'(x); bus.y0 = 10'(y); bus.wdata0 = wd;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic txn(input vec_t v, input string nm);
    int k, we0, re0, ov0, us0;
    bit got;
    logic err_got, oth_got;
    logic [31:0] rd_got;
    bit strobe = !v.err;
    we0 = we_tot; re0 = re_tot; ov0 = ovl_tot; us0 = uns_tot;
    err_got = 1'b0; oth_got = 1'b0; rd_got = '0;
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.x, v.y, v.wd);
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      if (v.port ? bus.ack1 : bus.ack0) begin
        got     = 1'b1;
        err_got = v.port ? bus.err1 : bus.err0;
        oth_got = v.port ? bus.ack0 : bus.ack1;
        rd_got  = bus.rdata;
      end else begin
        k++;
      end
    end
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 0, 0, '0);
    chk({nm, ".latency"}, 32'(k), 32'(v.lat));
    chk({nm, ".err"}, 32'(err_got), 32'(v.err));
    chk({nm, ".rdata"}, rd_got, v.rd);
    chk({nm, ".other_ack"}, 32'(oth_got), 32'd0);
    chk({nm, ".we_cycles"}, 32'(we_tot - we0), (strobe && v.we) ? 32'(WH) : 32'd0);
    chk({nm, ".re_cycles"}, 32'(re_tot - re0), (strobe && !v.we) ? 32'd1 : 32'd0);
    chk({nm, ".overlap"}, 32'(ovl_tot - ov0), 32'd0);
    if (strobe) chk({nm, ".mem_addr"}, 32'(s_addr), 32'(v.addr));
    if (strobe && v.we) begin
      chk({nm, ".mem_wdata"}, s_wdata, v.wd);
      chk({nm, ".stable"}, 32'(uns_tot - us0), 32'd0);
    end
    if (v.we && !v.err) ref_mem[v.addr] = v.wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    int   k;
    int   g;
    int   acks;

    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.strobes_acks", {26'd0, bus.mem_we, bus.mem_re, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
    chk("reset.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset.rdata", bus.rdata, 32'd0);

    vt[0] = '{1'b1, 1'b1, 16,   1,    32'hDEADBEEF, 16'd82,    1'b0, 4, 32'h0};
    vt[1] = '{1'b0, 1'b0, 0,    0,    32'h0,        16'd0,     1'b0, 3, 32'h12345678};
    vt[2] = '{1'b1, 1'b1, 640,  0,    32'h11111111, 16'd0,     1'b1, 1, 32'h0};
    vt[3] = '{1'b0, 1'b1, 639,  479,  32'hA5A5A5A5, 16'd38399, 1'b0, 4, 32'h0};
    vt[4] = '{1'b1, 1'b0, 7,    0,    32'h0,        16'd0,     1'b0, 3, 32'h12345678};
    vt[5] = '{1'b0, 1'b0, 639,  479,  32'h0,        16'd38399, 1'b0, 3, 32'hA5A5A5A5};
    vt[6] = '{1'b0, 1'b0, 0,    480,  32'h0,        16'd0,     1'b1, 1, 32'h0};
    vt[7] = '{1'b1, 1'b0, 1023, 1023, 32'h0,        16'd0,     1'b1, 1, 32'h0};
    vt[8] = '{1'b1, 1'b1, 8,    0,    32'h0BADCAFE, 16'd1,     1'b0, 4, 32'h0};
    vt[9] = '{1'b0, 1'b0, 15,   0,    32'h0,        16'd1,     1'b0, 3, 32'h0BADCAFE};
    for (int i = 0; i < 10; i++) begin
      txn(vt[i], $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
    end

    // Both ports request continuously; each re-asserts right after its skip cycle.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 3, 2, '0);
    drive(1'b1, 1'b1, 1'b0, 100, 5, '0);
    for (int i = 0; i < 6; i++) begin
      k = 0; g = -1;
      while (g < 0 && k < 40) begin
        @(negedge clk);
        if (bus.ack0)      g = 0;
        else if (bus.ack1) g = 1;
        else               k++;
      end
      chk($sformatf("rr.grant%0d", i), 32'(g), PRIO ? 32'd0 : 32'(i % 2));
      @(posedge clk); #1;
      if (g == 0) bus.req0 = 1'b0;
      if (g == 1) bus.req1 = 1'b0;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (6) @(posedge clk);

    // Reset during the second WRITE cycle aborts with no ack.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 32, 2, 32'hCAFEF00D);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_we && k < 20);
    chk("abort.write_started", 32'(bus.mem_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0);
    acks = ack_tot;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (4) @(posedge clk);
    chk("abort.no_ack", 32'(ack_tot - acks), 32'd0);
    ref_mem[164] = 32'hCAFEF00D;
    txn('{1'b0, 1'b0, 0, 0, 32'h0, 16'd0, 1'b0, 3, 32'h12345678}, "abort.read");
    repeat (2) @(posedge clk);

    // Randomized traffic; expectations come from pixel coordinates and a shadow memory.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   a;
      v.port = 1'($urandom_range(0, 1));
      v.we   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        v.x = int'($urandom_range(600, 1023));
        v.y = int'($urandom_range(0, 520));
      end else begin
        v.x = int'($urandom_range(0, 31));
        v.y = int'($urandom_range(0, 1));
      end
      v.wd   = $urandom;
      v.err  = (v.x >= W) || (v.y >= H);
      a      = (v.y * W + v.x) / PPW;
      v.addr = 16'(a);
      v.lat  = v.err ? 1 : (v.we ? WH + 1 : RL + 1);
      v.rd   = (v.err || v.we) ? 32'h0 : ref_mem[a];
      txn(v, $sformatf("rand%0d", i));
      repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
